// File: rtl/video_timing_gen.sv
// Raster timing generator and pixel-stream sequencer for a VGA-style encoder.
// Optional colour-bar source is built only when VIDEO_TEST_PATTERN_EN is defined.
module video_timing_gen #(
  parameter int          H_ACTIVE      = 640,
  parameter int          H_FP          = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BP          = 48,
  parameter int          V_ACTIVE      = 480,
  parameter int          V_FP          = 10,
  parameter int          V_SYNC        = 2,
  parameter int          V_BP          = 33,
  parameter logic        HSYNC_POL     = 1'b0,
  parameter logic        VSYNC_POL     = 1'b0,
  parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
  input  logic        clk_pixel,
  input  logic        reset_i,
  input  logic [23:0] pix_data_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic        test_pattern_i,
  output logic        vga_hsync_o,
  output logic        vga_vsync_o,
  output logic        vga_blank_o,
  output logic [7:0]  vga_r_o,
  output logic [7:0]  vga_g_o,
  output logic [7:0]  vga_b_o,
  output logic        frame_start_o,
  output logic        vblank_o,
  output logic        underflow_o,
  output logic [15:0] underflow_cnt_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  logic          hsync_q, vsync_q, blank_q;
  logic [23:0]   rgb_q, rgb_d;
  logic          fs_q, vb_q, uf_q;
  logic [15:0]   ucnt_q, ucnt_d;

  logic          active_c, hs_act_c, vs_act_c;
  logic          pat_c, under_c;

  // Raster position: h wraps every line and carries into v
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  assign active_c = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_act_c = (h_q >= H_SS) && (h_q < H_SE);
  assign vs_act_c = (v_q >= V_SS) && (v_q < V_SE);

`ifdef VIDEO_TEST_PATTERN_EN
  logic [2:0] bar_c;
  assign pat_c = test_pattern_i;
  assign bar_c = 3'((int'(h_q) * 8) / H_ACTIVE);
`else
  logic unused_tp;
  assign pat_c     = 1'b0;
  assign unused_tp = test_pattern_i;
`endif

  // Pixel source select: stream, underflow fill, colour bars or black
  always_comb begin
    rgb_d   = '0;
    under_c = 1'b0;
    if (active_c) begin
      if (pat_c) begin
`ifdef VIDEO_TEST_PATTERN_EN
        rgb_d = {{8{bar_c[2]}}, {8{bar_c[1]}}, {8{bar_c[0]}}};
`endif
      end else if (pix_valid_i) begin
        rgb_d = pix_data_i;
      end else begin
        rgb_d   = UNDERFLOW_RGB;
        under_c = 1'b1;
      end
    end
  end

  assign pix_ready_o = active_c & ~pat_c;

  // Underflow pixel count saturates rather than wrapping
  always_comb begin
    ucnt_d = ucnt_q;
    if (under_c && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  // Counter state
  always_ff @(posedge clk_pixel or posedge reset_i) begin
    if (reset_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Output registers: all sampled from the same (h,v) for encoder alignment
  always_ff @(posedge clk_pixel or posedge reset_i) begin
    if (reset_i) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      blank_q <= 1'b1;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      vb_q    <= 1'b0;
      uf_q    <= 1'b0;
      ucnt_q  <= '0;
    end else begin
      hsync_q <= hs_act_c ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= vs_act_c ? VSYNC_POL : ~VSYNC_POL;
      blank_q <= ~active_c;
      rgb_q   <= rgb_d;
      fs_q    <= (h_q == '0) && (v_q == '0);
      vb_q    <= (v_q >= V_ACT);
      uf_q    <= uf_q | under_c;
      ucnt_q  <= ucnt_d;
    end
  end

  assign vga_hsync_o     = hsync_q;
  assign vga_vsync_o     = vsync_q;
  assign vga_blank_o     = blank_q;
  assign vga_r_o         = rgb_q[23:16];
  assign vga_g_o         = rgb_q[15:8];
  assign vga_b_o         = rgb_q[7:0];
  assign frame_start_o   = fs_q;
  assign vblank_o        = vb_q;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ucnt_q;

endmodule
